// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-bank completer.
package apb_slave_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  localparam int REG_ID_IDX   = 0;
  localparam int REG_CNT_IDX  = 1;
  localparam int REG_CTRL_IDX = 2;
  localparam int WCNT_W       = 4;
endpackage

// File: rtl/apb_regbank_store.sv
// Register storage: RW array, transfer counter, byte-lane writes and read mux.
module apb_regbank_store
  import apb_slave_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NUM_REGS  = 8,
  parameter int IDXW      = 14,
  parameter logic [DATAWIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic                   inc_i,
  input  logic [IDXW-1:0]        idx_i,
  input  logic [DATAWIDTH-1:0]   wdata_i,
  input  logic [DATAWIDTH/8-1:0] strb_i,
  output logic [DATAWIDTH-1:0]   rdata_o,
  output logic [DATAWIDTH-1:0]   ctrl_o
);
  localparam int NB = DATAWIDTH / 8;

  // Slot k holds register index k+REG_CTRL_IDX; ID and XFER_CNT are not stored here.
  logic [DATAWIDTH-1:0] rw_q [NUM_REGS-2];
  logic [DATAWIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS - 2; i++) rw_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (inc_i) cnt_q <= cnt_q + 1'b1;
      if (we_i) begin
        for (int i = 0; i < NUM_REGS - 2; i++) begin
          if (32'(idx_i) == 32'(i + REG_CTRL_IDX)) begin
            for (int b = 0; b < NB; b++)
              if (strb_i[b]) rw_q[i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (32'(idx_i) == 32'(REG_ID_IDX))       rdata_o = ID_VALUE;
    else if (32'(idx_i) == 32'(REG_CNT_IDX)) rdata_o = cnt_q;
    else begin
      for (int i = 0; i < NUM_REGS - 2; i++)
        if (32'(idx_i) == 32'(i + REG_CTRL_IDX)) rdata_o = rw_q[i];
    end
  end

  assign ctrl_o = rw_q[REG_CTRL_IDX-2];
endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer with a small register bank and fixed wait states.
// Optional byte strobes: define APB_PSTRB_EN to add the PSTRB port.
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int ADDRWIDTH   = 16,
  parameter int DATAWIDTH   = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 1,
  parameter logic [DATAWIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   PCLKEN,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic [ADDRWIDTH-1:0]   PADDR,
  input  logic                   PWRITE,
  input  logic [DATAWIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATAWIDTH/8-1:0] PSTRB,
`endif
  output logic                   PREADY,
  output logic [DATAWIDTH-1:0]   PRDATA,
  output logic                   PSLVERR,
  output logic [DATAWIDTH-1:0]   REG_CTRL
);
  localparam int IDXW = ADDRWIDTH - 2;
  localparam int NB   = DATAWIDTH / 8;

  state_e                state_q;
  logic [WCNT_W-1:0]     cnt_q;
  logic [IDXW-1:0]       idx_q;
  logic                  wr_q;
  logic [DATAWIDTH-1:0]  wdata_q;
  logic [NB-1:0]         strb_q;
  logic                  ready, err, done, we;
  logic [DATAWIDTH-1:0]  rdata;
  logic                  unused_paddr;

  assign unused_paddr = ^PADDR[1:0];

  assign ready = (state_q == ACCESS) && (cnt_q == '0);
  assign err   = (32'(idx_q) >= 32'(NUM_REGS)) |
                 (wr_q & (32'(idx_q) <= 32'(REG_CNT_IDX)));
  assign done  = PCLKEN & ready & PSEL & PENABLE;
  assign we    = done & wr_q & ~err;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (PCLKEN) begin
      case (state_q)
        IDLE: if (PSEL && !PENABLE) begin
          idx_q   <= PADDR[ADDRWIDTH-1:2];
          wr_q    <= PWRITE;
          wdata_q <= PWDATA;
`ifdef APB_PSTRB_EN
          strb_q  <= PSTRB;
`else
          strb_q  <= '1;
`endif
          cnt_q   <= WCNT_W'(WAIT_STATES);
          state_q <= ACCESS;
        end
        ACCESS: begin
          // Initiator abort takes priority over wait countdown and completion.
          if (!PSEL)               state_q <= IDLE;
          else if (cnt_q != '0)    cnt_q   <= cnt_q - 1'b1;
          else if (PENABLE)        state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  apb_regbank_store #(
    .DATAWIDTH (DATAWIDTH),
    .NUM_REGS  (NUM_REGS),
    .IDXW      (IDXW),
    .ID_VALUE  (ID_VALUE)
  ) u_store (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .we_i    (we),
    .inc_i   (done),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .strb_i  (strb_q),
    .rdata_o (rdata),
    .ctrl_o  (REG_CTRL)
  );

  assign PREADY  = ready;
  assign PSLVERR = ready & err;
  assign PRDATA  = (ready && !wr_q) ? rdata : '0;
endmodule
